// File: rtl/unstacker.sv
// Serializes 128-bit memory chunks into 16-bit pixels, lowest pixel first.
// A two-slot ping-pong buffer keeps one pixel per clock flowing across chunk boundaries.
module unstacker (
    input  logic         clk,
    input  logic         rst,
    input  logic         chunk_tvalid,
    output logic         chunk_tready,
    input  logic [127:0] chunk_tdata,
    input  logic         chunk_tlast,
    input  logic [3:0]   chunk_tcount,
    output logic         pixel_tvalid,
    input  logic         pixel_tready,
    output logic [15:0]  pixel_tdata,
    output logic         pixel_tlast,
    output logic         busy
);

    typedef struct packed {
        logic [7:0][15:0] data;
        logic             last;
        logic [3:0]       n;
    } slot_t;

    slot_t       r_slot [2];
    logic [1:0]  r_full;
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [2:0]  r_idx;

    slot_t       w_rd_slot;
    logic [2:0]  w_last_idx;
    logic        w_at_end;
    logic        w_chunk_fire;
    logic        w_pixel_fire;
    logic [3:0]  w_wr_n;

    // Only a final chunk may be short; a nonsense count falls back to a full chunk.
    function automatic logic [3:0] f_pixel_count(input logic last, input logic [3:0] count);
        if (last && (count != 4'd0) && (count <= 4'd8))
            return count;
        return 4'd8;
    endfunction

    assign w_rd_slot    = r_slot[r_rd_ptr];
    assign w_last_idx   = 3'(w_rd_slot.n - 4'd1);
    assign w_at_end     = (r_idx == w_last_idx);
    assign w_wr_n       = f_pixel_count(chunk_tlast, chunk_tcount);

    assign chunk_tready = !r_full[r_wr_ptr];
    assign pixel_tvalid = r_full[r_rd_ptr];
    assign pixel_tlast  = r_full[r_rd_ptr] && w_rd_slot.last && w_at_end;
    assign pixel_tdata  = r_full[r_rd_ptr] ? w_rd_slot.data[r_idx] : 16'h0000;
    assign busy         = r_full[0] || r_full[1];

    assign w_chunk_fire = chunk_tvalid && chunk_tready;
    assign w_pixel_fire = pixel_tvalid && pixel_tready;

    // NOTE: slot payload is never read unless its full flag is set, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_chunk_fire) begin
            r_slot[r_wr_ptr] <= '{data: chunk_tdata, last: chunk_tlast, n: w_wr_n};
        end
    end

    // The write slot is always empty and the read slot always full when their
    // handshakes fire, so both updates to r_full touch different bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full   <= 2'b00;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_idx    <= 3'd0;
        end else begin
            if (w_chunk_fire) begin
                r_full[r_wr_ptr] <= 1'b1;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pixel_fire) begin
                if (w_at_end) begin
                    r_full[r_rd_ptr] <= 1'b0;
                    r_rd_ptr         <= ~r_rd_ptr;
                    r_idx            <= 3'd0;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_unstacker.sv
// Randomized and directed bench for unstacker; a pixel-queue model checks every cycle.
module tb_unstacker;

    logic         clk = 1'b0;
    logic         rst;
    logic         chunk_tvalid;
    logic         chunk_tready;
    logic [127:0] chunk_tdata;
    logic         chunk_tlast;
    logic [3:0]   chunk_tcount;
    logic         pixel_tvalid;
    logic         pixel_tready;
    logic [15:0]  pixel_tdata;
    logic         pixel_tlast;
    logic         busy;

    unstacker dut (
        .clk          (clk),
        .rst          (rst),
        .chunk_tvalid (chunk_tvalid),
        .chunk_tready (chunk_tready),
        .chunk_tdata  (chunk_tdata),
        .chunk_tlast  (chunk_tlast),
        .chunk_tcount (chunk_tcount),
        .pixel_tvalid (pixel_tvalid),
        .pixel_tready (pixel_tready),
        .pixel_tdata  (pixel_tdata),
        .pixel_tlast  (pixel_tlast),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] RAMP0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
    localparam logic [127:0] RAMP1 = 128'h0017_0016_0015_0014_0013_0012_0011_0010;
    localparam logic [127:0] RAMP2 = 128'h0027_0026_0025_0024_0023_0022_0021_0020;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    bit chk_en   = 1'b0;
    bit rand_mode = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: the stream of pixels still owed, plus how many chunks are held.
    typedef struct {
        logic [15:0] d;
        bit          last;
        bit          eoc;
    } pix_t;

    pix_t        m_q[$];
    int          m_chunks = 0;
    pix_t        m_head;
    pix_t        m_new;
    bit          m_in_fire;
    logic [127:0] m_data;
    int          m_n;

    logic [15:0] obs_data[$];
    bit          obs_last[$];
    int          obs_cyc[$];

    bit          prev_stall = 1'b0;
    logic [15:0] prev_d;
    logic        prev_l;

    function automatic int pix_count(input logic last, input logic [3:0] count);
        if (last && count >= 4'd1 && count <= 4'd8) return int'(count);
        return 8;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("chunk_tready", chunk_tready, m_chunks < 2);
            check("pixel_tvalid", pixel_tvalid, m_chunks > 0);
            check("busy", busy, m_chunks > 0);
            if (m_chunks > 0) begin
                check("pixel_tdata", pixel_tdata, m_q[0].d);
                check("pixel_tlast", pixel_tlast, m_q[0].last);
            end
            if (prev_stall && pixel_tvalid) begin
                check("stall_tdata_stable", pixel_tdata, prev_d);
                check("stall_tlast_stable", pixel_tlast, prev_l);
            end
            prev_stall = pixel_tvalid && !pixel_tready;
            prev_d     = pixel_tdata;
            prev_l     = pixel_tlast;

            if (rst) begin
                m_q.delete();
                m_chunks   = 0;
                prev_stall = 1'b0;
            end else begin
                m_in_fire = chunk_tvalid && (m_chunks < 2);
                if (m_chunks > 0 && pixel_tready) begin
                    obs_data.push_back(pixel_tdata);
                    obs_last.push_back(pixel_tlast);
                    obs_cyc.push_back(cyc);
                    m_head = m_q.pop_front();
                    if (m_head.eoc) m_chunks--;
                end
                if (m_in_fire) begin
                    m_data = chunk_tdata;
                    m_n    = pix_count(chunk_tlast, chunk_tcount);
                    for (int k = 0; k < m_n; k++) begin
                        m_new.d    = m_data[16*k +: 16];
                        m_new.eoc  = (k == m_n - 1);
                        m_new.last = chunk_tlast && m_new.eoc;
                        m_q.push_back(m_new);
                    end
                    m_chunks++;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            pixel_tready = 1'($urandom_range(0, 1));
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_chunk(input logic [127:0] d, input logic l, input logic [3:0] c);
        int waited = 0;
        chunk_tvalid = 1'b1;
        chunk_tdata  = d;
        chunk_tlast  = l;
        chunk_tcount = c;
        @(negedge clk);
        while (!chunk_tready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!chunk_tready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout chunk_tready stuck low, required 1");
        end
        @(posedge clk);
        #1;
        acc_cyc      = cyc;
        chunk_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited = 0;
        @(negedge clk);
        while ((busy || m_chunks != 0) && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (busy || m_chunks != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout busy=%0d model_chunks=%0d, required 0", busy, m_chunks);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_data.delete();
        obs_last.delete();
        obs_cyc.delete();
    endtask

    initial begin
        logic [127:0] d;
        int total;
        int waited;
        logic l;
        logic [3:0] c;

        rst          = 1'b1;
        chunk_tvalid = 1'b0;
        chunk_tdata  = '0;
        chunk_tlast  = 1'b0;
        chunk_tcount = 4'd0;
        pixel_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        check("reset_chunk_tready", chunk_tready, 1'b1);
        check("reset_pixel_tvalid", pixel_tvalid, 1'b0);
        check("reset_pixel_tlast", pixel_tlast, 1'b0);
        check("reset_busy", busy, 1'b0);

        // Single full chunk.
        pixel_tready = 1'b1;
        clear_obs();
        send_chunk(RAMP0, 1'b0, 4'd0);
        wait_idle();
        check("t1_count", obs_data.size(), 8);
        if (obs_data.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check("t1_pixel", obs_data[k], 16'(k));
                check("t1_tlast", obs_last[k], 1'b0);
            end
            check("t1_latency", obs_cyc[0], acc_cyc - 0);
            check("t1_span", obs_cyc[7] - obs_cyc[0], 7);
        end

        // Three back-to-back chunks, no bubbles.
        clear_obs();
        send_chunk(RAMP0, 1'b0, 4'd0);
        send_chunk(RAMP1, 1'b0, 4'd0);
        send_chunk(RAMP2, 1'b0, 4'd0);
        wait_idle();
        check("t2_count", obs_data.size(), 24);
        if (obs_data.size() == 24) begin
            check("t2_span", obs_cyc[23] - obs_cyc[0], 23);
            check("t2_px8", obs_data[8], 16'h0010);
            check("t2_px23", obs_data[23], 16'h0027);
        end

        // Truncated tlast chunk followed immediately by a full one.
        clear_obs();
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        d[47:0] = 48'hCCCC_BBBB_AAAA;
        send_chunk(d, 1'b1, 4'd3);
        send_chunk(RAMP1, 1'b0, 4'd0);
        wait_idle();
        check("t3_count", obs_data.size(), 11);
        if (obs_data.size() == 11) begin
            check("t3_px0", obs_data[0], 16'hAAAA);
            check("t3_px1", obs_data[1], 16'hBBBB);
            check("t3_px2", obs_data[2], 16'hCCCC);
            check("t3_last0", obs_last[0], 1'b0);
            check("t3_last1", obs_last[1], 1'b0);
            check("t3_last2", obs_last[2], 1'b1);
            check("t3_next_px0", obs_data[3], 16'h0010);
            check("t3_next_gap", obs_cyc[3] - obs_cyc[2], 1);
            check("t3_next_last", obs_last[10], 1'b0);
        end

        // tcount=0 on a tlast chunk means a full chunk.
        clear_obs();
        send_chunk(RAMP0, 1'b1, 4'd0);
        wait_idle();
        check("t3b_count", obs_data.size(), 8);
        if (obs_data.size() == 8) begin
            check("t3b_px7", obs_data[7], 16'h0007);
            check("t3b_last7", obs_last[7], 1'b1);
            check("t3b_last6", obs_last[6], 1'b0);
        end

        // Random backpressure over 16 random chunks.
        clear_obs();
        total     = 0;
        rand_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            l = 1'($urandom_range(0, 1));
            c = 4'($urandom_range(0, 15));
            total += pix_count(l, c);
            send_chunk(d, l, c);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        rand_mode = 1'b0;
        @(posedge clk);
        #2;
        pixel_tready = 1'b1;
        wait_idle();
        check("t4_total_pixels", obs_data.size(), total);

        // Reset after the third pixel with a second chunk buffered.
        clear_obs();
        send_chunk(RAMP0, 1'b0, 4'd0);
        send_chunk(RAMP2, 1'b0, 4'd0);
        waited = 0;
        while (obs_data.size() < 3 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("t5_reached_px3", obs_data.size(), 3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_pixel_tvalid", pixel_tvalid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_chunk_tready", chunk_tready, 1'b1);
        clear_obs();
        send_chunk(RAMP1, 1'b0, 4'd0);
        wait_idle();
        check("t5_count", obs_data.size(), 8);
        if (obs_data.size() == 8) check("t5_px0", obs_data[0], 16'h0010);

        // Both slots full, input held valid with no pixel drain for 20 cycles.
        clear_obs();
        pixel_tready = 1'b0;
        send_chunk(RAMP0, 1'b0, 4'd0);
        send_chunk(RAMP2, 1'b0, 4'd0);
        fork
            send_chunk(RAMP1, 1'b0, 4'd0);
            begin
                repeat (20) begin
                    @(posedge clk);
                    #1;
                end
                check("t6_hold_tready", chunk_tready, 1'b0);
                check("t6_hold_tdata", pixel_tdata, 16'h0000);
                pixel_tready = 1'b1;
            end
        join
        wait_idle();
        check("t6_count", obs_data.size(), 24);
        if (obs_data.size() == 24) begin
            check("t6_px0", obs_data[0], 16'h0000);
            check("t6_px8", obs_data[8], 16'h0020);
            check("t6_px16", obs_data[16], 16'h0010);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/unstacker.md
Name: unstacker

Overview:
- Inverse of the 16-to-128 pixel stacker.
- Accepts 128-bit MIG phrases (chunks) on an AXI-Stream-like input and serializes each into 16-bit pixels on an AXI-Stream-like output, least-significant 16 bits first.
- Sits on the memory read path, between the MIG read-data FIFO and the pixel consumer (display/audio pipeline).
- A two-slot ping-pong chunk buffer sustains one pixel per clock across chunk boundaries with no bubbles.

Parameters:
None. Widths are fixed: 128-bit chunk, 16-bit pixel, 8 pixels per chunk.

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
chunk_tvalid  input  1  input chunk valid
chunk_tready  output  1  block can accept a chunk this cycle
chunk_tdata  input  128  chunk; pixel k occupies bits [16k+15:16k]
chunk_tlast  input  1  chunk is the last of a frame/burst
chunk_tcount  input  4  valid pixels in chunk (1..8); used only when chunk_tlast=1
pixel_tvalid  output  1  output pixel valid
pixel_tready  input  1  downstream accepts pixel
pixel_tdata  output  16  current pixel
pixel_tlast  output  1  high on the final pixel of a tlast chunk
busy  output  1  high when either slot holds a chunk

Behaviour:
- Storage: two slots (A, B). Each slot holds data[127:0], last, n[3:0] (pixel count), and a full flag.
- Pointers: wr_ptr selects the slot written next; rd_ptr selects the slot being drained; idx[2:0] is the pixel index within the rd slot.
- Reset: all full flags 0, wr_ptr=rd_ptr=0, idx=0. Outputs after reset:
  - chunk_tready=1
  - pixel_tvalid=0
  - pixel_tlast=0
  - busy=0
  - pixel_tdata is don't-care, but 0 preferred.
- chunk_tready = !full[wr_ptr]. It is a function of registered state only, with no combinational path from pixel_tready.
- Chunk accept (chunk_tvalid && chunk_tready):
  - Write data and last into slot[wr_ptr]; set full; toggle wr_ptr.
  - If chunk_tlast=0, store n=8.
  - If chunk_tlast=1 and chunk_tcount is 1..8, store n=chunk_tcount.
  - If chunk_tlast=1 and chunk_tcount is 0 or >8, store n=8.
- Output (combinational from registers):
  - pixel_tvalid = full[rd_ptr]
  - pixel_tdata = slot[rd_ptr].data[16*idx +: 16]
  - pixel_tlast = full[rd_ptr] && slot[rd_ptr].last && (idx == n-1)
- Pixel accept (pixel_tvalid && pixel_tready):
  - If idx == n-1: clear full[rd_ptr], set idx=0, toggle rd_ptr.
  - Otherwise: idx <= idx+1.
- Latency: a chunk accepted at edge N presents its pixel 0 after edge N (pixel_tvalid high in cycle N+1) when its slot is the rd slot.
- Throughput: with pixel_tready held high, 8 pixels are emitted on 8 consecutive cycles per chunk, and the next chunk's pixel 0 follows on the very next cycle if that chunk was already accepted.
- Truncated chunk: a tlast chunk with n<8 emits exactly n pixels. The high pixels are discarded, and the next chunk begins immediately.
- Simultaneous accept and free in one cycle:
  - Both operate on different slots (write targets wr slot, which must be empty).
  - A slot freed in cycle N can be written no earlier than cycle N+1, because chunk_tready is registered-based.
- Both slots full: chunk_tready=0 until the rd slot drains.
- pixel_tready low: idx and all slot state hold. pixel_tdata and pixel_tlast stay stable while pixel_tvalid is high.
- Upstream must hold chunk data stable while chunk_tvalid is high and chunk_tready is low (AXI rule). The block does not latch on a valid that lacks a handshake.
- Reset mid-operation: buffered chunks and the partial pixel index are discarded; state returns to reset values on the next edge.
- busy = full[0] || full[1].

Test Plan:
- Single chunk 0x0007_0006_0005_0004_0003_0002_0001_0000, tlast=0, pixel_tready=1 -> pixels 0x0000..0x0007 on 8 consecutive cycles; pixel_tlast=0 throughout; pixel_tvalid rises 1 cycle after accept.
- Three back-to-back chunks, pixel_tready=1 -> 24 pixels with no bubble. chunk_tready drops to 0 while both slots are full and reasserts one cycle after a slot frees.
- tlast chunk with tcount=3, data low pixels 0xAAAA,0xBBBB,0xCCCC -> exactly 3 pixels; pixel_tlast high only on 0xCCCC; the following chunk's pixel 0 comes next cycle. A repeat with tcount=0 gives 8 pixels, with tlast on pixel 7.
- Random pixel_tready with ~50% duty over 16 chunks -> output sequence matches the scoreboard; pixel_tdata is stable whenever valid is high and ready is low; no chunk is lost or duplicated.
- Assert rst after the 3rd pixel of a chunk, with a second chunk buffered -> next cycle pixel_tvalid=0, busy=0, chunk_tready=1. A new chunk afterwards starts at pixel 0.
- chunk_tvalid held high with both slots full and pixel_tready=0 for 20 cycles -> no state change and no overwrite of slot data.
